// File: rtl/generator_addr_wr.sv
// generator_addr_wr
//   Write-side address generator for the output/partial-sum buffer. A start
//   pulse latches the tile origin base = 64*k + 4*j. The block then accepts
//   16 result words over a valid/ready handshake and issues one registered
//   buffer write per word. The writes cover a 4x4 tile: column-fast,
//   row-slow, with a row stride of END_ROW words.
//
//   Optional feature: define GEN_ADDR_WR_BOUNDS_EN to suppress writes whose
//   unwrapped address reaches HEIGHT and to raise a sticky err flag. Without
//   the macro, addresses wrap modulo HEIGHT and err is tied 0.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          one-cycle tile request, honoured only when idle
//   j, k           column-tile and plane index, latched with start
//   in_valid       result word present on in_data
//   in_data        result word
//   in_ready       beat accepted this cycle when in_valid is also high
//   wr_en          buffer write strobe (one cycle after the accepted beat)
//   wr_addr        buffer write address
//   wr_data        buffer write data
//   busy           tile in progress (RUN or DONE)
//   done           one-cycle completion pulse, coincident with last write
//   err            sticky out-of-range flag (bounds build only)
module generator_addr_wr #(
  parameter  int END_ROW = 16,
  parameter  int HEIGHT  = 32,
  parameter  int DW      = 16,
  localparam int AW      = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    j,
  input  logic [7:0]    k,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [23:0] base;
  logic [1:0]  col, row;
  logic        accept;
  logic [23:0] full;
  logic        wr_ok;
  logic        unused_full_hi;

  function automatic logic [23:0] tile_addr(input logic [23:0] b,
                                            input logic [1:0]  r,
                                            input logic [1:0]  c);
    return b + 24'(END_ROW) * {22'd0, r} + {22'd0, c};
  endfunction

  // Stage p0: handshake, control FSM and tile counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && row == 2'd3 && col == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      col  <= '0;
      row  <= '0;
    end else if (state == IDLE && start) begin
      base <= {10'd0, k, 6'd0} + {14'd0, j, 2'd0};
      col  <= '0;
      row  <= '0;
    end else if (accept) begin
      col <= col + 2'd1;
      if (col == 2'd3) row <= row + 2'd1;
    end
  end

  assign full           = tile_addr(base, row, col);
  assign unused_full_hi = ^full[23:AW];

`ifdef GEN_ADDR_WR_BOUNDS_EN
  assign wr_ok = (full < 24'(HEIGHT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err <= 1'b0;
    else if (accept && !wr_ok) err <= 1'b1;
  end
`else
  assign wr_ok = 1'b1;
  assign err   = 1'b0;
`endif

  // Stage p1: registered buffer write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept & wr_ok;
      if (accept) begin
        wr_addr <= full[AW-1:0];
        wr_data <= in_data;
      end
    end
  end

endmodule
